// File: rtl/i2s_sample_sched.sv
// i2s_sample_sched: codec power-up sequencer and once-per-frame requester mixer feeding an I2S transmitter.
// Optional macro SCHED_HOLD_LAST_EN: an underrun slot replays that requester's last accepted sample.
module i2s_sample_sched #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned NREQ           = 4,
    parameter int unsigned STARTUP_CYCLES = 8388608,
    parameter int unsigned ZERO_FRAMES    = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_enable,
    input  logic                  i_frame_tick,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    output logic [WIDTH-1:0]      o_sample,
    output logic                  o_mclk_en,
    output logic                  o_lr_en,
    output logic [2:0]            o_state,
    output logic [NREQ-1:0]       o_underrun
);
    localparam int unsigned AW = WIDTH + 3;
    localparam int unsigned CW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int unsigned FW = (ZERO_FRAMES > 1) ? $clog2(ZERO_FRAMES) : 1;
    localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_CHARGE = 3'd1,
        ST_PRIME  = 3'd2,
        ST_RUN    = 3'd3,
        ST_MUTE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              fetch_q, fetch_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [WIDTH-1:0]  sample_q, sample_d;
    logic              mclk_q, mclk_d;
    logic              lr_q, lr_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic [NREQ-1:0]   underrun_q, underrun_d;
    logic              start_fetch;
    logic              cur_valid;
    logic [WIDTH-1:0]  cur_data;
    logic [WIDTH-1:0]  contrib;
    logic [AW-1:0]     acc_sum;
`ifdef SCHED_HOLD_LAST_EN
    logic [WIDTH-1:0]  hold_q [NREQ];
    logic [WIDTH-1:0]  hold_d [NREQ];
    logic [WIDTH-1:0]  cur_hold;
`endif

    // Clamp the widened sum back into the signed WIDTH-bit range.
    function automatic logic [WIDTH-1:0] saturate(input logic [AW-1:0] a);
        if (a[AW-1:WIDTH-1] == {4{a[AW-1]}}) begin
            return a[WIDTH-1:0];
        end else if (a[AW-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    // Select the requester owning the current fetch slot.
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
`ifdef SCHED_HOLD_LAST_EN
        cur_hold  = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (slot_q == SW'(k)) begin
                cur_valid = i_req_valid[k];
                cur_data  = i_req_data[k*WIDTH +: WIDTH];
`ifdef SCHED_HOLD_LAST_EN
                cur_hold  = hold_q[k];
`endif
            end
        end
`ifdef SCHED_HOLD_LAST_EN
        contrib = cur_valid ? cur_data : cur_hold;
`else
        contrib = cur_valid ? cur_data : '0;
`endif
        acc_sum = acc_q + {{3{contrib[WIDTH-1]}}, contrib};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fcnt_d      = fcnt_q;
        fetch_d     = fetch_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        pending_d   = pending_q;
        sample_d    = sample_q;
        mclk_d      = mclk_q;
        lr_d        = lr_q;
        ready_d     = '0;
        underrun_d  = underrun_q;
        start_fetch = 1'b0;
`ifdef SCHED_HOLD_LAST_EN
        hold_d      = hold_q;
`endif
        unique case (state_q)
            ST_OFF: begin
                sample_d = '0;
                mclk_d   = 1'b0;
                lr_d     = 1'b0;
                fetch_d  = 1'b0;
                if (i_enable) begin
                    state_d    = ST_CHARGE;
                    cnt_d      = '0;
                    mclk_d     = 1'b1;
                    underrun_d = '0;
                end
            end
            ST_CHARGE: begin
                if (!i_enable) begin
                    state_d = ST_OFF;
                    mclk_d  = 1'b0;
                end else if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
                    state_d = ST_PRIME;
                    lr_d    = 1'b1;
                    fcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PRIME: begin
                pending_d = '0;
                if (i_frame_tick) sample_d = '0;
                if (!i_enable) begin
                    state_d = ST_MUTE;
                    fcnt_d  = '0;
                end else if (i_frame_tick) begin
                    if (fcnt_q == FW'(ZERO_FRAMES - 1)) begin
                        state_d     = ST_RUN;
                        start_fetch = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (i_frame_tick) sample_d = pending_q;
                if (!i_enable) begin
                    state_d = ST_MUTE;
                    fcnt_d  = '0;
                    fetch_d = 1'b0;
                end else if (i_frame_tick) begin
                    start_fetch = 1'b1;
                end else if (fetch_q) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (slot_q == SW'(k)) begin
                            if (!cur_valid) underrun_d[k] = 1'b1;
`ifdef SCHED_HOLD_LAST_EN
                            else hold_d[k] = cur_data;
`endif
                        end
                    end
                    if (slot_q == SW'(NREQ - 1)) begin
                        fetch_d   = 1'b0;
                        pending_d = saturate(acc_sum);
                    end else begin
                        slot_d  = slot_q + SW'(1);
                        acc_d   = acc_sum;
                        ready_d = NREQ'(1) << (slot_q + SW'(1));
                    end
                end
            end
            ST_MUTE: begin
                if (i_enable) begin
                    state_d = ST_PRIME;
                    fcnt_d  = '0;
                    if (i_frame_tick) sample_d = '0;
                end else if (i_frame_tick) begin
                    sample_d = '0;
                    if (fcnt_q == FW'(ZERO_FRAMES - 1)) begin
                        state_d = ST_OFF;
                        mclk_d  = 1'b0;
                        lr_d    = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
        // A tick always restarts the fetch from slot 0, discarding any partial sum.
        if (start_fetch) begin
            fetch_d = 1'b1;
            slot_d  = '0;
            acc_d   = '0;
            ready_d = NREQ'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            fetch_q    <= 1'b0;
            slot_q     <= '0;
            acc_q      <= '0;
            pending_q  <= '0;
            sample_q   <= '0;
            mclk_q     <= 1'b0;
            lr_q       <= 1'b0;
            ready_q    <= '0;
            underrun_q <= '0;
`ifdef SCHED_HOLD_LAST_EN
            for (int k = 0; k < NREQ; k++) hold_q[k] <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            fetch_q    <= fetch_d;
            slot_q     <= slot_d;
            acc_q      <= acc_d;
            pending_q  <= pending_d;
            sample_q   <= sample_d;
            mclk_q     <= mclk_d;
            lr_q       <= lr_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
`ifdef SCHED_HOLD_LAST_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign o_req_ready = ready_q;
    assign o_sample    = sample_q;
    assign o_mclk_en   = mclk_q;
    assign o_lr_en     = lr_q;
    assign o_state     = state_q;
    assign o_underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_sample_sched.sv
// tb_i2s_sample_sched: randomized frame-level bench for i2s_sample_sched with a sum-and-clamp reference model.
// Runs the default build (SCHED_HOLD_LAST_EN undefined).
module tb_i2s_sample_sched;
    localparam int WIDTH   = 16;
    localparam int NREQ    = 4;
    localparam int STARTUP = 64;
    localparam int ZF      = 3;
    localparam int FRAME   = 32;
    localparam int SMAX    = 2 ** (WIDTH - 1) - 1;
    localparam int SMIN    = -(2 ** (WIDTH - 1));

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  i_enable;
    logic                  i_frame_tick;
    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ*WIDTH-1:0] i_req_data;
    logic [NREQ-1:0]       o_req_ready;
    logic [WIDTH-1:0]      o_sample;
    logic                  o_mclk_en;
    logic                  o_lr_en;
    logic [2:0]            o_state;
    logic [NREQ-1:0]       o_underrun;

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] pend;
    logic [NREQ-1:0]  uflags;

    always #5 clk = ~clk;

    i2s_sample_sched #(
        .WIDTH(WIDTH), .NREQ(NREQ), .STARTUP_CYCLES(STARTUP), .ZERO_FRAMES(ZF)
    ) dut (
        .clk(clk), .resetn(resetn), .i_enable(i_enable), .i_frame_tick(i_frame_tick),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
        .o_sample(o_sample), .o_mclk_en(o_mclk_en), .o_lr_en(o_lr_en),
        .o_state(o_state), .o_underrun(o_underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected mix: signed sum of the valid requesters, clamped to the sample range.
    function automatic logic [WIDTH-1:0] mix_model();
        int s = 0;
        for (int k = 0; k < NREQ; k++)
            if (i_req_valid[k]) s += int'($signed(i_req_data[k*WIDTH +: WIDTH]));
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return WIDTH'(s);
    endfunction

    task automatic set_req(input logic [NREQ-1:0] v, input int d0, input int d1, input int d2, input int d3);
        i_req_valid = v;
        i_req_data  = {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
    endtask

    task automatic rand_req(input int invalid_pct);
        for (int k = 0; k < NREQ; k++) begin
            i_req_valid[k] = ($urandom_range(99) >= invalid_pct);
            case ($urandom_range(3))
                0:       i_req_data[k*WIDTH +: WIDTH] = WIDTH'(SMAX);
                1:       i_req_data[k*WIDTH +: WIDTH] = WIDTH'(SMIN);
                default: i_req_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            endcase
        end
    endtask

    // One frame: tick, then FRAME-1 idle cycles; checks the loaded sample, flags and grant pattern.
    task automatic frame(input logic [WIDTH-1:0] exp_s, input bit fetches, input int retick_at);
        int since;
        i_frame_tick = 1'b1;
        cyc();
        i_frame_tick = 1'b0;
        since = 1;
        check_eq("sample", 32'(o_sample), 32'(exp_s));
        check_eq("underrun", 32'(o_underrun), 32'(uflags));
        for (int c = 1; c < FRAME; c++) begin
            check_eq("ready", 32'(o_req_ready),
                     (fetches && since <= NREQ) ? (32'd1 << (since - 1)) : 32'd0);
            if (c == retick_at) i_frame_tick = 1'b1;
            cyc();
            i_frame_tick = 1'b0;
            if (c == retick_at) begin
                since = 1;
                check_eq("retick_sample", 32'(o_sample), 32'(exp_s));
            end else begin
                since++;
            end
        end
        if (fetches) begin
            pend   = mix_model();
            uflags = uflags | ~i_req_valid;
        end
    endtask

    task automatic power_up();
        int n = 0;
        i_enable = 1'b1;
        cyc();
        check_eq("mclk_rise", 32'(o_mclk_en), 32'd1);
        check_eq("lr_low_charge", 32'(o_lr_en), 32'd0);
        check_eq("state_charge", 32'(o_state), 32'd1);
        check_eq("underrun_clr", 32'(o_underrun), 32'd0);
        uflags = '0;
        pend   = '0;
        while (!o_lr_en && n < 4 * STARTUP) begin
            cyc();
            n++;
        end
        check_eq("lr_delay", 32'(n), 32'(STARTUP));
        check_eq("state_prime", 32'(o_state), 32'd2);
        check_eq("mclk_prime", 32'(o_mclk_en), 32'd1);
    endtask

    // Zero frames of PRIME; the last tick enters RUN and fetches the currently driven inputs.
    task automatic prime_to_run();
        for (int f = 0; f < ZF - 1; f++) begin
            frame('0, 1'b0, 0);
            check_eq("prime_hold", 32'(o_state), 32'd2);
        end
        frame('0, 1'b1, 0);
        check_eq("run_entry", 32'(o_state), 32'd3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; i_enable = 1'b0; i_frame_tick = 1'b0;
        i_req_valid = '0; i_req_data = '0; pend = '0; uflags = '0;
        repeat (3) cyc();
        check_eq("rst_state", 32'(o_state), 32'd0);
        check_eq("rst_sample", 32'(o_sample), 32'd0);
        check_eq("rst_mclk", 32'(o_mclk_en), 32'd0);
        check_eq("rst_lr", 32'(o_lr_en), 32'd0);
        check_eq("rst_ready", 32'(o_req_ready), 32'd0);
        check_eq("rst_underrun", 32'(o_underrun), 32'd0);
        resetn = 1'b1;
        repeat (2) cyc();
        check_eq("off_idle", 32'({o_state, o_mclk_en, o_lr_en}), 32'd0);

        // Power-up, then the mix 100 - 50 + 7 + 0 fetched on the RUN-entry tick.
        power_up();
        set_req(4'b1111, 100, -50, 7, 0);
        prime_to_run();
        check_eq("mix_model", 32'(pend), 32'd57);

        set_req(4'b1111, SMAX, SMAX, SMAX, SMAX);
        frame(pend, 1'b1, 0);
        set_req(4'b1111, SMIN, SMIN, SMIN, SMIN);
        frame(pend, 1'b1, 0);
        set_req(4'b1011, 1000, 1000, 1000, 1000);
        frame(pend, 1'b1, 0);
        rand_req(0);
        frame(pend, 1'b1, 0);
        check_eq("underrun_req2", 32'(o_underrun), 32'h4);

        for (int f = 0; f < 16; f++) begin
            rand_req(25);
            frame(pend, 1'b1, 0);
        end

        // Tick landing on slot 1 restarts the fetch.
        rand_req(0);
        frame(pend, 1'b1, 2);
        rand_req(0);
        frame(pend, 1'b1, 0);

        // Shutdown in the middle of a fetch; pending is left untouched.
        i_frame_tick = 1'b1;
        cyc();
        i_frame_tick = 1'b0;
        check_eq("shut_tick_sample", 32'(o_sample), 32'(pend));
        cyc();
        check_eq("shut_slot1", 32'(o_req_ready), 32'h2);
        i_enable = 1'b0;
        cyc();
        check_eq("mute_state", 32'(o_state), 32'd4);
        check_eq("mute_ready", 32'(o_req_ready), 32'd0);
        check_eq("mute_en", 32'({o_mclk_en, o_lr_en}), 32'h3);
        check_eq("mute_hold_sample", 32'(o_sample), 32'(pend));
        repeat (FRAME - 3) cyc();
        for (int f = 1; f <= ZF; f++) begin
            frame('0, 1'b0, 0);
            check_eq("mute_seq_state", 32'(o_state), (f < ZF) ? 32'd4 : 32'd0);
            check_eq("mute_seq_en", 32'({o_mclk_en, o_lr_en}), (f < ZF) ? 32'h3 : 32'h0);
        end

        // Second power-up, then re-enable from MUTE goes straight to PRIME.
        power_up();
        rand_req(25);
        prime_to_run();
        rand_req(25);
        frame(pend, 1'b1, 0);
        i_enable = 1'b0;
        cyc();
        check_eq("mute2_state", 32'(o_state), 32'd4);
        repeat (FRAME - 2) cyc();
        frame('0, 1'b0, 0);
        i_enable = 1'b1;
        cyc();
        check_eq("reprime_state", 32'(o_state), 32'd2);
        check_eq("reprime_en", 32'({o_mclk_en, o_lr_en}), 32'h3);
        repeat (FRAME - 2) cyc();
        pend = '0;
        set_req(4'b0111, 1234, -34, 800, 5);
        prime_to_run();
        rand_req(0);
        frame(pend, 1'b1, 0);

        // Reset asserted during slot 1 of a fetch.
        i_frame_tick = 1'b1;
        cyc();
        i_frame_tick = 1'b0;
        cyc();
        check_eq("pre_rst_slot1", 32'(o_req_ready), 32'h2);
        resetn   = 1'b0;
        i_enable = 1'b0;
        cyc();
        check_eq("midrst_state", 32'(o_state), 32'd0);
        check_eq("midrst_sample", 32'(o_sample), 32'd0);
        check_eq("midrst_ready", 32'(o_req_ready), 32'd0);
        check_eq("midrst_en", 32'({o_mclk_en, o_lr_en}), 32'd0);
        check_eq("midrst_underrun", 32'(o_underrun), 32'd0);
        resetn = 1'b1;
        repeat (4) cyc();
        check_eq("post_rst_off", 32'(o_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_sample_sched.md
Name: i2s_sample_sched

Overview:
Controller and arbiter in front of the I2S transmitter, running in the same clock domain.
- Sequences codec power-up: MCLK charge delay, zero-fill frames, run, and mute on shutdown.
- Once per frame, polls NREQ sample requesters in fixed order and sums their samples with saturation.
- Presents one stable WIDTH-bit sample to the transmitter's sample input, together with its clock enables.

Parameters:
WIDTH, 16, sample width in bits (signed two's complement).
NREQ, 4, number of requesters (1..8).
STARTUP_CYCLES, 8388608, clk cycles of MCLK-only charging before LRCLK is enabled (2^23 at 8.192 MHz is about 1.02 s).
ZERO_FRAMES, 10, frames of zero data after LRCLK starts, and again before LRCLK stops.

Ports:
clk  in  1  system/I2S master clock
resetn  in  1  synchronous active-low reset
i_enable  in  1  level; 1 = bring audio up, 0 = shut down
i_frame_tick  in  1  one-cycle pulse when the transmitter loads its sample register
i_req_valid  in  NREQ  per-requester sample valid
i_req_data  in  NREQ*WIDTH  requester k occupies bits [k*WIDTH +: WIDTH]
o_req_ready  out  NREQ  one-hot grant; high only in that requester's fetch slot
o_sample  out  WIDTH  sample to the transmitter; changes only on the cycle after i_frame_tick
o_mclk_en  out  1  gate for the transmitter's MCLK output
o_lr_en  out  1  gate for the transmitter's LRCLK/SCLK/SDIN outputs
o_state  out  3  OFF=0, CHARGE=1, PRIME=2, RUN=3, MUTE=4
o_underrun  out  NREQ  sticky per-requester underrun flags

Behaviour:
Reset:
- Clock and reset: one clock; reset is synchronous and active-low (clk, resetn). Reset is sampled only on the clk rising edge.
- resetn=0 forces state OFF and clears the counters, the accumulator and the pending register.
- Reset values: o_sample=0, o_mclk_en=0, o_lr_en=0, o_req_ready=0, o_underrun=0.
- Reset mid-operation aborts any fetch with no handshake completed.

OFF:
- All outputs held at their reset values.
- i_enable=1 -> CHARGE, cycle counter cleared.

CHARGE:
- o_mclk_en=1.
- Counts clk cycles; when the count reaches STARTUP_CYCLES-1 -> PRIME.
- i_enable=0 -> OFF.

PRIME:
- o_mclk_en=1, o_lr_en=1, o_sample=0.
- Counts i_frame_tick; after the ZERO_FRAMES-th tick -> RUN. The fetch starts on that same tick.
- i_enable=0 -> MUTE with the frame count cleared.

RUN, fetch sequence (started on every i_frame_tick):
- Slots k=0..NREQ-1 on consecutive cycles after the tick; o_req_ready[k]=1 during slot k only.
- Transfer in slot k iff i_req_valid[k]=1. The data is sign-extended into an accumulator of WIDTH+3 bits.
- No valid in slot k: contributes 0 and sets o_underrun[k]. Flags clear only on reset or on entry to CHARGE.
- On the cycle after the last slot, the accumulator saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and is written to the pending register.

RUN, output timing:
- o_sample <= pending on the cycle after each i_frame_tick, so latency is one frame.
- The first RUN frame outputs 0.

RUN, boundary cases:
- i_frame_tick during an active fetch: present the previous pending value, abort the fetch and restart from slot 0. No flags are set for unvisited slots.
- i_enable=0 -> MUTE. The fetch in progress is abandoned at the next cycle and o_req_ready drops.

MUTE:
- o_sample=0 from the next tick onward; o_lr_en=1, o_mclk_en=1.
- After ZERO_FRAMES ticks -> OFF.
- i_enable=1 during MUTE -> PRIME with the frame count cleared (no re-charge).

General rules:
- o_mclk_en and o_lr_en are registered, and change only on state transitions.
- o_lr_en never rises without o_mclk_en having been high for at least STARTUP_CYCLES cycles.

Optional Feature:
SCHED_HOLD_LAST_EN
- Defined: each requester keeps a last-accepted-sample register, cleared on reset. An underrun slot contributes that register instead of 0, and o_underrun[k] is still set.
- Undefined: an underrun slot contributes 0, and no per-requester registers exist.

Test Plan:
1. Power-up: reset, i_enable=1, STARTUP_CYCLES=64, ZERO_FRAMES=3, tick every 32 cycles.
   - o_mclk_en rises 1 cycle after enable; o_lr_en rises exactly 64 cycles later.
   - o_sample=0 for 3 frames, then RUN.
2. Mix: NREQ=4, all valid with data 100, -50, 7, 0.
   - ready pulses one-hot on cycles tick+1..tick+4.
   - o_sample=57 after the following tick; o_underrun=0.
3. Saturation: all four requesters at 0x7FFF -> o_sample=0x7FFF. All four at 0x8000 -> o_sample=0x8000.
4. Underrun: requester 2 invalid, others 1000.
   - Without the macro, o_sample=3000 and o_underrun=4'b0100.
   - With SCHED_HOLD_LAST_EN and a prior value of 500 from requester 2, o_sample=3500.
5. Shutdown: drop i_enable in RUN -> MUTE; exactly ZERO_FRAMES zero frames; then o_lr_en=0 and o_mclk_en=0 in OFF. Re-enable during MUTE -> PRIME without a new CHARGE.
6. Disruption: resetn=0 during slot 1 of a fetch -> next cycle all outputs are zero and state is OFF. A tick during a fetch restarts the fetch at slot 0.
